axil_regfile_slave: RTL
=======================

// Module: axil_regfile_slave
// PURPOSE
//  Parametrised AXI4-Lite slave register file. Sits on the SoC AXI4-Lite bus as a peripheral front end.
//  - NUM_REGS software registers; bytes written under WSTRB control.
//  - Optional read-only status registers, driven by hardware.
//  - AW and W channels are decoupled and fully backpressured. B and R are held until accepted.
//  - Out-of-range accesses return SLVERR.
// PARAMETERS
//  ADDR_W    6              byte-address width; index = ADDR[ADDR_W-1:BYTE_LSB]
//  DATA_W    32             data width, 32 or 64; STRB_W = DATA_W/8, BYTE_LSB = $clog2(STRB_W)
//  NUM_REGS  8              implemented registers, 1..2**(ADDR_W-BYTE_LSB)
//  RO_MASK   '0 [NUM_REGS]  bit i=1: reg i is read-only and reads status_i[i]
// PORTS
//  ACLK      in   1                clock
//  ARESETn   in   1                reset, asynchronous, active-low
//  AWADDR    in   ADDR_W           write address
//  AWVALID   in   1                |  AWREADY  out  1
//  WDATA     in   DATA_W           |  WSTRB    in   STRB_W  byte enables
//  WVALID    in   1                |  WREADY   out  1
//  BRESP     out  2                |  BVALID   out  1  |  BREADY  in  1
//  ARADDR    in   ADDR_W           |  ARVALID  in   1  |  ARREADY out 1
//  RDATA     out  DATA_W           |  RRESP    out  2
//  RVALID    out  1                |  RREADY   in   1
//  status_i  in   NUM_REGS*DATA_W  hardware values for RO registers, reg i at [i*DATA_W +: DATA_W]
//  regs_o    out  NUM_REGS*DATA_W  current register contents (RO slots carry status_i)
//  wr_pulse_o out NUM_REGS         1-cycle strobe: reg i committed this cycle
// BEHAVIOUR
//  Reset:
//  - Applies asynchronously on ARESETn low.
//  - All READY/VALID outputs go to 0; BRESP/RRESP go to OKAY; RDATA goes to 0.
//  - Writable registers go to 0; aw_held and w_held clear; wr_pulse_o goes to 0.
//  - Reset mid-transaction drops the transaction with no response. The master must reissue it.
//  Write path, one outstanding write:
//  - AW holding slot: AWREADY = !aw_held. An AW handshake stores AWADDR and sets aw_held.
//  - W holding slot: WREADY = !w_held. A W handshake stores WDATA/WSTRB and sets w_held.
//  - AW and W may arrive in either order or the same cycle. Neither waits for the other.
//  - Commit happens in the cycle where aw_held && w_held && !BVALID.
//    - Byte b of the register is written where WSTRB[b]=1.
//    - wr_pulse_o[idx] is set next cycle. BVALID=1 next cycle.
//    - aw_held and w_held clear on the commit.
//  - Minimum latency: AW+W handshake in cycle N, commit in N+1, BVALID in N+2.
//  - BVALID and BRESP stay stable until BREADY. They drop the cycle after the handshake.
//  - A new AW/W may be accepted while B is pending. It commits only after the B handshake.
//  - Error writes: idx >= NUM_REGS, or RO_MASK[idx]=1.
//    - BRESP = SLVERR (2'b10). No register changes. No wr_pulse.
//  - WSTRB=0 is a legal write: BRESP=OKAY, no data change, wr_pulse still fires.
//  Read path, one outstanding read:
//  - ARREADY = !RVALID.
//  - An AR handshake in cycle N gives RVALID=1 in N+1.
//  - RDATA is captured at that edge from the pre-commit register value (read-before-write on a same-cycle commit).
//  - RDATA, RRESP and RVALID stay stable until RREADY.
//  - RO registers return status_i as sampled at the AR handshake.
//  - idx >= NUM_REGS: RDATA = 0, RRESP = SLVERR.
//  - Back-to-back reads: the R handshake in cycle M drops RVALID, so ARREADY is high in M+1. Max rate is one read per 2 cycles.
//  Address handling:
//  - Address bits below BYTE_LSB are ignored.
//  - Address bits above the index are absent by construction (ADDR_W sizes the index).
//  Concurrency:
//  - Read and write channels are independent. Both may handshake in the same cycle.
//  - No combinational path from any input to any READY or VALID output.
// STRUCTURE
//  - Shared package axil_pkg: axil_resp_e {OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11}.
//    The register-file FSM typedefs also live in axil_pkg.
//  - Sub-module axil_regfile_core holds the register array and strobe/RO merge.
//    - Inputs: we, widx, wdata, wstrb, ridx.
//    - Outputs: rdata, regs_o, wr_pulse_o.
//  - axil_regfile_slave keeps only the channel logic: holding slots, B FSM {B_IDLE,B_WAIT}, R FSM {R_IDLE,R_WAIT}.
// TESTING (defaults: DATA_W=32, NUM_REGS=8, RO_MASK=8'h80)
//  1. AW addr 0x04 and W 0xDEADBEEF/strb F in the same cycle, BREADY=1
//     -> BVALID 2 cycles later with OKAY; wr_pulse_o=8'h02; a read of 0x04 returns 0xDEADBEEF.
//  2. W first (0x11223344, strb 4'b0101), AW 0x08 three cycles later, reg2 preloaded 0xFFFFFFFF
//     -> reg2 = 0xFF22FF44; exactly one BVALID.
//  3. Hold BREADY=0 for 5 cycles after a write
//     -> BVALID/BRESP stable; a second AW+W is accepted, then commits only after the first B handshake.
//  4. Write 0x1C (RO) and 0x20 (>= NUM_REGS)
//     -> both return BRESP=SLVERR; regs unchanged; no wr_pulse.
//     Read 0x20 -> RDATA=0, RRESP=SLVERR.
//     Read 0x1C with status_i[7]=0xCAFE0001 -> RDATA=0xCAFE0001, OKAY.
//  5. Read 0x0C while a write to 0x0C commits in the same cycle (old 0x1, new 0x2)
//     -> RDATA=0x1; a follow-up read returns 0x2.
//     Hold RREADY=0 for 4 cycles -> RDATA held and ARREADY=0.
//  6. Pull ARESETn low while aw_held=1 and RVALID=1
//     -> all VALID/READY outputs 0 immediately; regs 0; after release, a fresh write/read completes normally.

Source files
------------

// File: rtl/axil_pkg.sv
// Shared AXI4-Lite types: response codes, register-file channel FSM states
// and the debug snapshot exported by the slave.
package axil_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axil_resp_e;

    typedef enum logic {
        B_IDLE = 1'b0,
        B_WAIT = 1'b1
    } b_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_WAIT = 1'b1
    } r_state_e;

    typedef struct packed {
        b_state_e b_state;
        r_state_e r_state;
        logic     aw_held;
        logic     w_held;
        logic     ready_en;
    } axil_dbg_t;

endpackage

// File: rtl/axil_regfile_core.sv
// Register array with byte-strobe writes, read-only status merge, index
// decode and the per-register commit strobe.
module axil_regfile_core #(
    parameter int                  DATA_W   = 32,
    parameter int                  NUM_REGS = 8,
    parameter int                  IDX_W    = 4,
    parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
    input  logic                       ACLK,
    input  logic                       ARESETn,
    input  logic                       we,
    input  logic [IDX_W-1:0]           widx,
    input  logic [DATA_W-1:0]          wdata,
    input  logic [DATA_W/8-1:0]        wstrb,
    input  logic [IDX_W-1:0]           ridx,
    input  logic [NUM_REGS*DATA_W-1:0] status_i,
    output logic [DATA_W-1:0]          rdata,
    output logic                       werr,
    output logic                       rerr,
    output logic [NUM_REGS*DATA_W-1:0] regs_o,
    output logic [NUM_REGS-1:0]        wr_pulse_o
);

    localparam int STRB_W = DATA_W / 8;

    logic [NUM_REGS-1:0] whit;
    logic [NUM_REGS-1:0] rhit;

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        assign whit[gi] = (widx == IDX_W'(gi));
        assign rhit[gi] = (ridx == IDX_W'(gi));

        if (RO_MASK[gi]) begin : g_ro
            assign regs_o[gi*DATA_W +: DATA_W] = status_i[gi*DATA_W +: DATA_W];
        end else begin : g_rw
            logic [DATA_W-1:0] q;
            logic              unused_status;

            assign unused_status = ^status_i[gi*DATA_W +: DATA_W];
            assign regs_o[gi*DATA_W +: DATA_W] = q;

            always_ff @(posedge ACLK or negedge ARESETn) begin
                if (!ARESETn) begin
                    q <= '0;
                end else if (we && whit[gi]) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (wstrb[b]) q[b*8 +: 8] <= wdata[b*8 +: 8];
                    end
                end
            end
        end
    end

    // An index that hits no writable slot covers both out-of-range and RO.
    assign werr = !(|(whit & ~RO_MASK));
    assign rerr = !(|rhit);

    always_comb begin
        rdata = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rhit[i]) rdata = regs_o[i*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_pulse_o <= '0;
        end else begin
            wr_pulse_o <= (we && !werr) ? (whit & ~RO_MASK) : '0;
        end
    end

endmodule

// File: rtl/axil_regfile_slave.sv
// AXI4-Lite slave front end: AW/W holding slots, B and R response FSMs,
// wrapped around axil_regfile_core.
module axil_regfile_slave
    import axil_pkg::*;
#(
    parameter int                  ADDR_W   = 6,
    parameter int                  DATA_W   = 32,
    parameter int                  NUM_REGS = 8,
    parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
    input  logic                       ACLK,
    input  logic                       ARESETn,
    input  logic [ADDR_W-1:0]          AWADDR,
    input  logic                       AWVALID,
    output logic                       AWREADY,
    input  logic [DATA_W-1:0]          WDATA,
    input  logic [DATA_W/8-1:0]        WSTRB,
    input  logic                       WVALID,
    output logic                       WREADY,
    output logic [1:0]                 BRESP,
    output logic                       BVALID,
    input  logic                       BREADY,
    input  logic [ADDR_W-1:0]          ARADDR,
    input  logic                       ARVALID,
    output logic                       ARREADY,
    output logic [DATA_W-1:0]          RDATA,
    output logic [1:0]                 RRESP,
    output logic                       RVALID,
    input  logic                       RREADY,
    input  logic [NUM_REGS*DATA_W-1:0] status_i,
    output logic [NUM_REGS*DATA_W-1:0] regs_o,
    output logic [NUM_REGS-1:0]        wr_pulse_o,
    output axil_dbg_t                  dbg_o
);

    localparam int STRB_W   = DATA_W / 8;
    localparam int BYTE_LSB = $clog2(STRB_W);
    localparam int IDX_W    = ADDR_W - BYTE_LSB;

    // A transfer happens on a rising edge where VALID && READY; every READY
    // and VALID here is a pure function of flops, never of a bus input.
    logic              ready_en;
    logic              aw_held;
    logic [IDX_W-1:0]  aw_idx_q;
    logic              w_held;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;
    b_state_e          b_state, b_state_nxt;
    r_state_e          r_state, r_state_nxt;
    axil_resp_e        bresp_q, rresp_q;
    logic [DATA_W-1:0] rdata_q;
    logic              aw_hs, w_hs, ar_hs, commit;
    logic [DATA_W-1:0] core_rdata;
    logic              core_werr, core_rerr;
    logic              unused_addr_lsb;

    assign unused_addr_lsb = ^{AWADDR[BYTE_LSB-1:0], ARADDR[BYTE_LSB-1:0]};

    assign AWREADY = ready_en && !aw_held;
    assign WREADY  = ready_en && !w_held;
    assign ARREADY = ready_en && (r_state == R_IDLE);
    assign BVALID  = (b_state == B_WAIT);
    assign RVALID  = (r_state == R_WAIT);
    assign BRESP   = bresp_q;
    assign RRESP   = rresp_q;
    assign RDATA   = rdata_q;

    assign aw_hs  = AWVALID && AWREADY;
    assign w_hs   = WVALID && WREADY;
    assign ar_hs  = ARVALID && ARREADY;
    assign commit = aw_held && w_held && (b_state == B_IDLE);

    // Keeps every READY low while reset is asserted and for one edge after.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) ready_en <= 1'b0;
        else          ready_en <= 1'b1;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            aw_held  <= 1'b0;
            aw_idx_q <= '0;
        end else if (commit) begin
            aw_held <= 1'b0;
        end else if (aw_hs) begin
            aw_held  <= 1'b1;
            aw_idx_q <= AWADDR[ADDR_W-1:BYTE_LSB];
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_held  <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else if (commit) begin
            w_held <= 1'b0;
        end else if (w_hs) begin
            w_held  <= 1'b1;
            wdata_q <= WDATA;
            wstrb_q <= WSTRB;
        end
    end

    always_comb begin
        b_state_nxt = b_state;
        case (b_state)
            B_IDLE:  if (commit) b_state_nxt = B_WAIT;
            B_WAIT:  if (BREADY) b_state_nxt = B_IDLE;
            default: b_state_nxt = B_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            b_state <= B_IDLE;
            bresp_q <= OKAY;
        end else begin
            b_state <= b_state_nxt;
            if (commit) bresp_q <= core_werr ? SLVERR : OKAY;
        end
    end

    always_comb begin
        r_state_nxt = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs)  r_state_nxt = R_WAIT;
            R_WAIT:  if (RREADY) r_state_nxt = R_IDLE;
            default: r_state_nxt = R_IDLE;
        endcase
    end

    // Read data is taken from the flop outputs, so a same-edge commit is not yet visible.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state <= R_IDLE;
            rresp_q <= OKAY;
            rdata_q <= '0;
        end else begin
            r_state <= r_state_nxt;
            if (ar_hs) begin
                rdata_q <= core_rdata;
                rresp_q <= core_rerr ? SLVERR : OKAY;
            end
        end
    end

    axil_regfile_core #(
        .DATA_W  (DATA_W),
        .NUM_REGS(NUM_REGS),
        .IDX_W   (IDX_W),
        .RO_MASK (RO_MASK)
    ) u_core (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .we        (commit),
        .widx      (aw_idx_q),
        .wdata     (wdata_q),
        .wstrb     (wstrb_q),
        .ridx      (ARADDR[ADDR_W-1:BYTE_LSB]),
        .status_i  (status_i),
        .rdata     (core_rdata),
        .werr      (core_werr),
        .rerr      (core_rerr),
        .regs_o    (regs_o),
        .wr_pulse_o(wr_pulse_o)
    );

    assign dbg_o = '{b_state: b_state, r_state: r_state, aw_held: aw_held,
                     w_held: w_held, ready_en: ready_en};

endmodule
